// File: rtl/dma_write_burst_ctrl.sv
// rtl/dma_write_burst_ctrl.sv - DMA write path: drains a show-ahead FIFO into Avalon-MM fixed-address write bursts
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, start_addr, len    transfer request (sampled in IDLE only)
//   abort                     stop the transfer at the next burst boundary
//   busy, done, aborted       transfer status; aborted qualifies the done pulse
//   err_underrun              sticky: a beat was presented while the FIFO was empty
//   fifo_lv, fifo_ne, fifo_q  show-ahead FIFO level / not-empty / head data
//   fifo_re                   FIFO pop
//   av_*                      Avalon-MM write master (address, burstcount, write, writedata, waitrequest)

module dma_write_burst_ctrl #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int FW       = 4,
    parameter int LW       = 16,
    parameter int MAXBURST = 8,
    parameter int BCW      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   start_addr,
    input  logic [LW-1:0]   len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            err_underrun,
    input  logic [FW:0]     fifo_lv,
    input  logic            fifo_ne,
    input  logic [DW-1:0]   fifo_q,
    output logic            fifo_re,
    output logic [AW-1:0]   av_address,
    output logic [BCW-1:0]  av_burstcount,
    output logic            av_write,
    output logic [DW-1:0]   av_writedata,
    input  logic            av_waitrequest
);

    // Common width for comparing the FIFO level against the burst size.
    localparam int CW  = (LW > FW + 1) ? LW : FW + 1;
    localparam int BPW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [AW-1:0]   cur_addr;
    logic [LW-1:0]   rem;
    logic [LW-1:0]   nb;
    logic [BCW-1:0]  beat;
    logic [CW-1:0]   lv_ext;
    logic [CW-1:0]   nb_ext;
    logic [AW-1:0]   addr_step;
    logic            level_ok;
    logic            accept;
    logic            last_beat;

    // Burst size and launch qualification.
    always_comb begin
        nb        = (rem > LW'(MAXBURST)) ? LW'(MAXBURST) : rem;
        lv_ext    = CW'(fifo_lv);
        nb_ext    = CW'(nb);
        level_ok  = (lv_ext >= nb_ext);
        addr_step = AW'(nb) * AW'(BPW);
        accept    = av_write & ~av_waitrequest;
        last_beat = accept && (beat == BCW'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort is only looked at in WAIT so a burst in
    // flight always runs to completion.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    next_state = S_DONE;
                end else if (level_ok) begin
                    next_state = S_BURST;
                end
            end
            S_BURST: begin
                if (last_beat) begin
                    // nb <= rem, so rem == nb means nothing is left after this burst.
                    next_state = (rem == nb) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Combinational outputs: the FIFO head is the write data, and a pop
    // happens exactly when the slave takes a beat.
    always_comb begin
        fifo_re      = accept;
        av_writedata = fifo_q;
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            err_underrun  <= 1'b0;
            av_write      <= 1'b0;
            av_address    <= '0;
            av_burstcount <= '0;
            cur_addr      <= '0;
            rem           <= '0;
            beat          <= '0;
        end else begin
            busy         <= (next_state != S_IDLE);
            done         <= (next_state == S_DONE);
            aborted      <= (state == S_WAIT) && abort;
            err_underrun <= err_underrun | (av_write & ~fifo_ne);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr <= start_addr;
                        rem      <= len;
                    end
                end
                S_WAIT: begin
                    if (next_state == S_BURST) begin
                        av_address    <= cur_addr;
                        av_burstcount <= BCW'(nb);
                        beat          <= BCW'(nb);
                        av_write      <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (accept) begin
                        beat <= beat - BCW'(1);
                    end
                    if (last_beat) begin
                        av_write <= 1'b0;
                        rem      <= rem - nb;
                        cur_addr <= cur_addr + addr_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_burst_ctrl.sv
// tb/tb_dma_write_burst_ctrl.sv - scoreboard bench for dma_write_burst_ctrl

module tb_dma_write_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [15:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err_underrun;
    logic [4:0]  fifo_lv;
    logic        fifo_ne;
    logic [31:0] fifo_q;
    logic        fifo_re;
    logic [31:0] av_address;
    logic [3:0]  av_burstcount;
    logic        av_write;
    logic [31:0] av_writedata;
    logic        av_waitrequest;

    dma_write_burst_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .len            (len),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .err_underrun   (err_underrun),
        .fifo_lv        (fifo_lv),
        .fifo_ne        (fifo_ne),
        .fifo_q         (fifo_q),
        .fifo_re        (fifo_re),
        .av_address     (av_address),
        .av_burstcount  (av_burstcount),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_waitrequest (av_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Show-ahead FIFO model, depth 16.
    logic        push_en;
    logic [31:0] push_data;
    logic        fifo_clr;
    logic [31:0] fmem [16];
    logic [3:0]  rd_ptr;
    logic [3:0]  wr_ptr;
    logic [4:0]  fcount;

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push_en) begin
                fmem[wr_ptr] <= push_data;
                wr_ptr       <= wr_ptr + 4'd1;
            end
            if (fifo_re) rd_ptr <= rd_ptr + 4'd1;
            if (push_en && !fifo_re) fcount <= fcount + 5'd1;
            else if (!push_en && fifo_re) fcount <= fcount - 5'd1;
        end
    end

    assign fifo_lv = fcount;
    assign fifo_ne = (fcount != 5'd0);
    assign fifo_q  = fmem[rd_ptr];

    // Scoreboard queues.
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  cnt;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic ab;
        int   gap;
    } done_t;

    beat_t exp_q[$];
    done_t done_q[$];

    task automatic exp_burst(input logic [31:0] addr, input logic [3:0] cnt, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < int'(cnt); k++) begin
            b.addr = addr;
            b.cnt  = cnt;
            b.data = base + 32'(k);
            exp_q.push_back(b);
        end
    endtask

    task automatic exp_done(input logic ab, input int gap);
        done_t d;
        d.ab  = ab;
        d.gap = gap;
        done_q.push_back(d);
    endtask

    // Monitor: samples one time unit before each rising edge.
    always begin : monitor
        beat_t b;
        done_t d;
        int    since_beat;
        logic  prev_write;
        logic  prev_done;
        since_beat = 0;
        prev_write = 1'b0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_write = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (av_write && !prev_write) begin
                    check("launch_level_sufficient", 64'(fifo_lv >= 5'(av_burstcount)), 64'd1);
                end
                if (av_write && av_waitrequest) begin
                    check("stall_fifo_re", 64'(fifo_re), 64'd0);
                    if (exp_q.size() > 0) begin
                        b = exp_q[0];
                        check("stall_addr", 64'(av_address), 64'(b.addr));
                        check("stall_count", 64'(av_burstcount), 64'(b.cnt));
                        check("stall_data", 64'(av_writedata), 64'(b.data));
                    end
                end
                if (av_write && !av_waitrequest) begin
                    pops++;
                    since_beat = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(av_address), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_addr", 64'(av_address), 64'(b.addr));
                        check("beat_count", 64'(av_burstcount), 64'(b.cnt));
                        check("beat_data", 64'(av_writedata), 64'(b.data));
                    end
                end else begin
                    since_beat++;
                end
                if (done) begin
                    check("done_single_cycle", 64'(prev_done), 64'd0);
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_aborted", 64'(aborted), 64'(d.ab));
                        if (d.gap != 0) check("done_latency", 64'(since_beat), 64'(d.gap));
                    end
                end
                prev_write = av_write;
                prev_done  = done;
            end
        end
    end

    // Stimulus helpers.
    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_en   = 1'b1;
            push_data = base + 32'(i);
        end
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] addr, input logic [15:0] n);
        @(negedge clk);
        start      = 1'b1;
        start_addr = addr;
        len        = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check({name, "_idle_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_write(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (av_write) break;
            @(negedge clk);
        end
        check({name, "_write_timeout"}, 64'(av_write), 64'd1);
    endtask

    bit wseq [14];
    int p0;

    initial begin
        wseq[0] = 0;  wseq[1] = 1;  wseq[2] = 1;  wseq[3] = 1;  wseq[4] = 0;
        wseq[5] = 0;  wseq[6] = 0;  wseq[7] = 1;  wseq[8] = 1;  wseq[9] = 1;
        wseq[10] = 0; wseq[11] = 0; wseq[12] = 0; wseq[13] = 0;

        rst = 1'b1; fifo_clr = 1'b1; start = 1'b0; start_addr = '0; len = '0;
        abort = 1'b0; av_waitrequest = 1'b0; push_en = 1'b0; push_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_underrun", 64'(err_underrun), 64'd0);
        check("rst_write", 64'(av_write), 64'd0);
        check("rst_address", 64'(av_address), 64'd0);
        check("rst_burstcount", 64'(av_burstcount), 64'd0);
        rst = 1'b0; fifo_clr = 1'b0;
        @(negedge clk);

        // Main transfer: 20 words, third burst waits for more data.
        p0 = pops;
        push_words(16, 32'hA000_0000);
        exp_burst(32'h1000, 4'd8, 32'hA000_0000);
        exp_burst(32'h1020, 4'd8, 32'hA000_0008);
        exp_burst(32'h1040, 4'd4, 32'hA000_0010);
        exp_done(1'b0, 1);
        do_start(32'h1000, 16'd20);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (pops >= p0 + 16) break;
        end
        check("t1_first16_pops", 64'(pops - p0), 64'd16);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t1_hold_no_write", 64'(av_write), 64'd0);
        end
        push_words(4, 32'hA000_0010);
        wait_idle("t1");
        check("t1_total_pops", 64'(pops - p0), 64'd20);

        // Zero-length transfer.
        p0 = pops;
        exp_done(1'b0, 0);
        @(negedge clk);
        start = 1'b1; start_addr = 32'h2000; len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("t2_done", 64'(done), 64'd1);
        check("t2_aborted", 64'(aborted), 64'd0);
        check("t2_write", 64'(av_write), 64'd0);
        @(negedge clk);
        check("t2_done_drop", 64'(done), 64'd0);
        check("t2_busy_drop", 64'(busy), 64'd0);
        check("t2_pops", 64'(pops - p0), 64'd0);

        // Burst of 8 with stalls on beats 2 and 5.
        p0 = pops;
        push_words(8, 32'hB000_0000);
        exp_burst(32'h3000, 4'd8, 32'hB000_0000);
        exp_done(1'b0, 1);
        do_start(32'h3000, 16'd8);
        wait_write("t3");
        for (int i = 0; i < 14; i++) begin
            av_waitrequest = wseq[i];
            @(negedge clk);
        end
        av_waitrequest = 1'b0;
        wait_idle("t3");
        check("t3_pops", 64'(pops - p0), 64'd8);

        // Level held below the burst size, then raised.
        p0 = pops;
        push_words(3, 32'hC000_0000);
        exp_burst(32'h4000, 4'd8, 32'hC000_0000);
        exp_done(1'b0, 1);
        do_start(32'h4000, 16'd8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_low_level_no_write", 64'(av_write), 64'd0);
        end
        push_words(5, 32'hC000_0003);
        check("t4_write_before_sample", 64'(av_write), 64'd0);
        @(negedge clk);
        check("t4_write_next_edge", 64'(av_write), 64'd1);
        wait_idle("t4");
        check("t4_pops", 64'(pops - p0), 64'd8);

        // Abort during the first burst of a 16-word transfer.
        p0 = pops;
        push_words(16, 32'hD000_0000);
        exp_burst(32'h5000, 4'd8, 32'hD000_0000);
        exp_done(1'b1, 2);
        do_start(32'h5000, 16'd16);
        wait_write("t5");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        wait_idle("t5");
        abort = 1'b0;
        check("t5_pops", 64'(pops - p0), 64'd8);
        check("t5_underrun", 64'(err_underrun), 64'd0);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;

        // Reset on beat 3, then a fresh transfer.
        push_words(8, 32'hE000_0000);
        exp_burst(32'h6000, 4'd8, 32'hE000_0000);
        do_start(32'h6000, 16'd8);
        wait_write("t6");
        repeat (2) @(negedge clk);
        rst = 1'b1; fifo_clr = 1'b1;
        @(negedge clk);
        check("t6_rst_write", 64'(av_write), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_count", 64'(av_burstcount), 64'd0);
        exp_q.delete();
        rst = 1'b0; fifo_clr = 1'b0;
        @(negedge clk);
        p0 = pops;
        push_words(4, 32'hF000_0000);
        exp_burst(32'h7000, 4'd4, 32'hF000_0000);
        exp_done(1'b0, 1);
        do_start(32'h7000, 16'd4);
        wait_idle("t6");
        check("t6_fresh_pops", 64'(pops - p0), 64'd4);

        repeat (3) @(negedge clk);
        check("end_beats_left", 64'(exp_q.size()), 64'd0);
        check("end_dones_left", 64'(done_q.size()), 64'd0);
        check("end_underrun", 64'(err_underrun), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
